// File: rtl/irq_aggregator_pkg.sv
// Shared constants and helpers for the interrupt aggregator.
// Register map, data width and the VECTOR priority encoder.
package irq_aggregator_pkg;

    localparam int DW            = 16;
    localparam int VEC_VALID_BIT = 15;

    localparam logic [2:0] ADDR_PENDING = 3'd0;
    localparam logic [2:0] ADDR_MASK    = 3'd1;
    localparam logic [2:0] ADDR_EDGE    = 3'd2;
    localparam logic [2:0] ADDR_RAW     = 3'd3;
    localparam logic [2:0] ADDR_VECTOR  = 3'd4;
    localparam logic [2:0] ADDR_FORCE   = 3'd5;

    // Index of the lowest set bit; lowest index has the highest priority.
    function automatic logic [3:0] prio_enc(input logic [DW-1:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = DW - 1; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_aggregator_sync_edge.sv
// Per-line input synchronizer with a one-cycle delayed copy.
// Produces the synchronized level and its rising-edge pulse.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic s_o,
    output logic rise_o
);

    logic s;
    logic s_d_q;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign s = d_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] ff_q;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    ff_q <= '0;
                end else begin
                    ff_q <= {ff_q[SYNC_STAGES-2:0], d_i};
                end
            end
            assign s = ff_q[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_d_q <= 1'b0;
        end else begin
            s_d_q <= s;
        end
    end

    assign s_o    = s;
    assign rise_o = s & ~s_d_q;

endmodule

// File: rtl/irq_aggregator.sv
// Avalon-MM interrupt aggregator: edge/level pending latch, mask,
// software force, registered CPU irq and a one-read priority vector.
module irq_aggregator
    import irq_aggregator_pkg::*;
#(
    parameter int N_IRQ       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [DW-1:0]    writedata,
    output logic [DW-1:0]    readdata,
    input  logic [N_IRQ-1:0] irq_in,
    output logic             irq
);

    logic [N_IRQ-1:0] s;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] wd;
    logic [N_IRQ-1:0] set;
    logic [N_IRQ-1:0] clr;
    logic [N_IRQ-1:0] pending_q;
    logic [N_IRQ-1:0] pending_d;
    logic [N_IRQ-1:0] mask_q;
    logic [N_IRQ-1:0] edge_q;
    logic [DW-1:0]    pm;
    logic [DW-1:0]    vector;
    logic [DW-1:0]    readdata_d;
    logic [DW-1:0]    readdata_q;
    logic             irq_q;
    logic             wr;
    logic             unused_wd;

    genvar gi;
    generate
        for (gi = 0; gi < N_IRQ; gi++) begin : g_line
            irq_sync_edge #(
                .SYNC_STAGES(SYNC_STAGES)
            ) u_sync (
                .clk    (clk),
                .reset_n(reset_n),
                .d_i    (irq_in[gi]),
                .s_o    (s[gi]),
                .rise_o (rise[gi])
            );
        end
    endgenerate

    assign wr        = chipselect & ~write_n;
    assign wd        = writedata[N_IRQ-1:0];
    assign unused_wd = ^writedata;

    // Set beats a simultaneous W1C on the same bit.
    always_comb begin
        set = (edge_q & rise) | (~edge_q & s);
        clr = '0;
        if (wr && address == ADDR_FORCE) set = set | wd;
        if (wr && address == ADDR_PENDING) clr = wd;
        pending_d = set | (pending_q & ~clr);
    end

    assign pm = DW'(pending_q & mask_q);

    always_comb begin
        vector = '0;
        if (|pm) begin
            vector[VEC_VALID_BIT] = 1'b1;
            vector[3:0]           = prio_enc(pm);
        end
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_PENDING: readdata_d = DW'(pending_q);
            ADDR_MASK:    readdata_d = DW'(mask_q);
            ADDR_EDGE:    readdata_d = DW'(edge_q);
            ADDR_RAW:     readdata_d = DW'(s);
            ADDR_VECTOR:  readdata_d = vector;
            default:      readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q  <= '0;
            mask_q     <= '0;
            edge_q     <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            readdata_q <= readdata_d;
            irq_q      <= |pm;
            if (wr && address == ADDR_MASK) mask_q <= wd;
            if (wr && address == ADDR_EDGE) edge_q <= wd;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_irq_aggregator.sv
// Bench for irq_aggregator: cycle model compared every cycle,
// plus directed register reads with literal expectations.
module tb_irq_aggregator;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic [7:0]  irq_in;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    irq_aggregator #(
        .N_IRQ      (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .irq_in    (irq_in),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Model: pending/mask/edge as plain words, inputs seen two edges late.
    logic [7:0]  m_pend, m_mask, m_edge;
    logic [15:0] m_rd;
    logic        m_irq;
    logic [7:0]  hist[$];

    always @(posedge clk or negedge reset_n) begin : model
        logic [7:0]  sv, sdv, setv, clrv, pmv, wd8;
        logic [15:0] vec;
        logic        wen;
        if (!reset_n) begin
            m_pend = 0; m_mask = 0; m_edge = 0;
            m_rd = 0; m_irq = 0;
            hist = '{8'h00, 8'h00, 8'h00};
        end else begin
            sv  = hist[hist.size()-2];
            sdv = hist[hist.size()-3];
            wen = chipselect && !write_n;
            wd8 = writedata[7:0];
            pmv = m_pend & m_mask;
            vec = 16'h0;
            for (int i = 7; i >= 0; i--)
                if (pmv[i]) vec = 16'h8000 | 16'(i);
            case (address)
                3'd0: m_rd = {8'h00, m_pend};
                3'd1: m_rd = {8'h00, m_mask};
                3'd2: m_rd = {8'h00, m_edge};
                3'd3: m_rd = {8'h00, sv};
                3'd4: m_rd = vec;
                default: m_rd = 16'h0;
            endcase
            m_irq = (pmv != 0);
            setv = 0;
            for (int i = 0; i < 8; i++)
                setv[i] = m_edge[i] ? (sv[i] && !sdv[i]) : sv[i];
            if (wen && address == 3'd5) setv = setv | wd8;
            clrv = (wen && address == 3'd0) ? wd8 : 8'h00;
            m_pend = setv | (m_pend & ~clrv);
            if (wen && address == 3'd1) m_mask = wd8;
            if (wen && address == 3'd2) m_edge = wd8;
            hist.push_back(irq_in);
            if (hist.size() > 3) void'(hist.pop_front());
        end
    end

    always @(negedge clk) begin
        check("model_readdata", readdata, m_rd);
        check("model_irq", {15'h0, irq}, {15'h0, m_irq});
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        cyc();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, input logic [15:0] exp,
                      input string name);
        address = a;
        cyc();
        check(name, readdata, exp);
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 16'h0;
        irq_in     = 8'h00;
        repeat (3) cyc();
        reset_n = 1'b1;

        for (int a = 0; a < 6; a++)
            rd(3'(a), 16'h0000, "reset_read");
        check("reset_irq", {15'h0, irq}, 16'h0);

        // Level path on bit 0
        wr(3'd1, 16'h0001);
        irq_in = 8'h01;
        repeat (3) cyc();
        check("lvl_irq_early", {15'h0, irq}, 16'h0);
        cyc();
        check("lvl_irq_3edges", {15'h0, irq}, 16'h1);
        rd(3'd4, 16'h8000, "lvl_vector");
        wr(3'd0, 16'h0001);
        rd(3'd0, 16'h0001, "lvl_w1c_resets");
        irq_in = 8'h00;
        repeat (3) cyc();
        wr(3'd0, 16'h0001);
        check("lvl_irq_lag", {15'h0, irq}, 16'h1);
        rd(3'd0, 16'h0000, "lvl_cleared");
        check("lvl_irq_off", {15'h0, irq}, 16'h0);

        // Edge path on bit 2
        wr(3'd2, 16'h0004);
        wr(3'd1, 16'h0004);
        irq_in = 8'h04;
        cyc();
        irq_in = 8'h00;
        repeat (4) cyc();
        rd(3'd0, 16'h0004, "edge_pending");
        rd(3'd4, 16'h8002, "edge_vector");
        wr(3'd0, 16'h0004);
        cyc();
        rd(3'd0, 16'h0000, "edge_cleared");
        check("edge_irq_off", {15'h0, irq}, 16'h0);

        // Priority and mask
        wr(3'd1, 16'h0080);
        wr(3'd5, 16'h00A0);
        rd(3'd0, 16'h00A0, "force_pending");
        rd(3'd4, 16'h8007, "prio_vec_masked");
        check("prio_irq", {15'h0, irq}, 16'h1);
        wr(3'd1, 16'h00A0);
        rd(3'd4, 16'h8005, "prio_vec_low");
        rd(3'd5, 16'h0000, "force_reads0");
        wr(3'd0, 16'h00A0);

        // Rising edge on bit 3 coincides with W1C of bit 3
        wr(3'd2, 16'h000C);
        wr(3'd5, 16'h0008);
        irq_in = 8'h08;
        cyc();
        cyc();
        wr(3'd0, 16'h0008);
        rd(3'd0, 16'h0008, "set_beats_w1c");
        irq_in = 8'h00;
        repeat (2) cyc();
        wr(3'd0, 16'h0008);
        rd(3'd0, 16'h0000, "w1c_alone");

        // Unimplemented addresses/bits, raw read
        wr(3'd6, 16'hFFFF);
        rd(3'd6, 16'h0000, "addr6_reads0");
        wr(3'd1, 16'hFF01);
        rd(3'd1, 16'h0001, "mask_high_bits");
        irq_in = 8'h12;
        cyc();
        cyc();
        rd(3'd3, 16'h0012, "raw_read");
        irq_in = 8'h00;
        repeat (3) cyc();
        wr(3'd0, 16'h00FF);
        rd(3'd0, 16'h0000, "all_cleared");

        // Asynchronous reset mid-operation
        wr(3'd2, 16'h0000);
        wr(3'd1, 16'h00FF);
        wr(3'd5, 16'h00FF);
        address = 3'd0;
        cyc();
        check("pre_reset_irq", {15'h0, irq}, 16'h1);
        check("pre_reset_pend", readdata, 16'h00FF);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_irq", {15'h0, irq}, 16'h0);
        check("async_readdata", readdata, 16'h0000);
        cyc();
        reset_n = 1'b1;
        rd(3'd1, 16'h0000, "mask_after_reset");
        rd(3'd0, 16'h0000, "pend_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
